// File: rtl/iot_monitor_multi.sv
// iot_monitor_multi: per-channel active-device counters with a registered
// aggregate total, sticky overflow/underflow flags and hysteresis alarms.
//
// Event interface: change[i] is a single-cycle strobe, sampled on every rising
// edge. It is always accepted (no stall). on_off[i] qualifies the direction
// only while change[i]=1. clear[i] overrides any event on the same channel.
//
// The alarm FSM state register drives alarm[i] directly (1 = ALARM), so the
// FSM state is always observable on that port.
module iot_monitor_multi #(
  parameter int WIDTH       = 8,
  parameter int CHANNELS    = 4,
  parameter bit SATURATE    = 1'b1,
  parameter int HIGH_THRESH = 200,
  parameter int LOW_THRESH  = 50,
  localparam int TW         = WIDTH + $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       change,
  input  logic [CHANNELS-1:0]       on_off,
  input  logic [CHANNELS-1:0]       clear,
  output logic [CHANNELS*WIDTH-1:0] counter_out,
  output logic [TW-1:0]             total_out,
  output logic [CHANNELS-1:0]       overflow,
  output logic [CHANNELS-1:0]       alarm,
  output logic                      any_alarm
);

  localparam logic [WIDTH-1:0] MAX_V  = '1;
  localparam logic [WIDTH-1:0] ZERO_V = '0;
  localparam logic [WIDTH-1:0] ONE_V  = WIDTH'(1);
  localparam logic [WIDTH-1:0] HI_T   = WIDTH'(HIGH_THRESH);
  localparam logic [WIDTH-1:0] LO_T   = WIDTH'(LOW_THRESH);

  typedef enum logic {
    A_IDLE  = 1'b0,
    A_ALARM = 1'b1
  } alarm_state_e;

  logic [WIDTH-1:0]    cnt_q [CHANNELS];
  logic [WIDTH-1:0]    cnt_d [CHANNELS];
  logic [CHANNELS-1:0] ovf_q, ovf_d;
  alarm_state_e        alm_q [CHANNELS];
  alarm_state_e        alm_d [CHANNELS];
  logic [TW-1:0]       total_q, total_d;
  logic                any_q, any_d;

  // Counter and sticky-flag next state: clear, then up/down with boundary handling.
  always_comb begin
    ovf_d = ovf_q;
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (clear[i]) begin
        cnt_d[i] = ZERO_V;
        ovf_d[i] = 1'b0;
      end else if (change[i] && on_off[i]) begin
        if (cnt_q[i] != MAX_V) begin
          cnt_d[i] = cnt_q[i] + ONE_V;
        end else begin
          cnt_d[i] = SATURATE ? MAX_V : ZERO_V;
          ovf_d[i] = 1'b1;
        end
      end else if (change[i]) begin
        if (cnt_q[i] != ZERO_V) begin
          cnt_d[i] = cnt_q[i] - ONE_V;
        end else begin
          cnt_d[i] = SATURATE ? ZERO_V : MAX_V;
          ovf_d[i] = 1'b1;
        end
      end
    end
  end

  // Alarm FSM next state from the registered counters, plus aggregate total and OR.
  always_comb begin
    total_d = '0;
    any_d   = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      alm_d[i] = alm_q[i];
      case (alm_q[i])
        A_IDLE:  if (cnt_q[i] >= HI_T) alm_d[i] = A_ALARM;
        A_ALARM: if (cnt_q[i] <= LO_T) alm_d[i] = A_IDLE;
        default: alm_d[i] = A_IDLE;
      endcase
      total_d = total_d + TW'(cnt_q[i]);
      any_d   = any_d | (alm_q[i] == A_ALARM);
    end
  end

  // State registers, all cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= ZERO_V;
        alm_q[i] <= A_IDLE;
      end
      ovf_q   <= '0;
      total_q <= '0;
      any_q   <= 1'b0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= cnt_d[i];
        alm_q[i] <= alm_d[i];
      end
      ovf_q   <= ovf_d;
      total_q <= total_d;
      any_q   <= any_d;
    end
  end

  // Pack per-channel registers onto the output ports.
  always_comb begin
    counter_out = '0;
    alarm       = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      counter_out[i*WIDTH +: WIDTH] = cnt_q[i];
      alarm[i]                      = (alm_q[i] == A_ALARM);
    end
  end

  assign total_out = total_q;
  assign overflow  = ovf_q;
  assign any_alarm = any_q;

endmodule

// File: tb/tb_iot_monitor_multi.sv
// Bench for iot_monitor_multi: a saturating and a wrapping instance share one
// stimulus stream and are both compared against an integer reference model.
module tb_iot_monitor_multi;

  localparam int W    = 8;
  localparam int N    = 4;
  localparam int TW   = 10;
  localparam int MAXV = 255;
  localparam int HI   = 200;
  localparam int LO   = 50;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] change = '0;
  logic [N-1:0] on_off = '0;
  logic [N-1:0] clear  = '0;

  always #5 clk = ~clk;

  logic [N*W-1:0] s_cnt, w_cnt;
  logic [TW-1:0]  s_tot, w_tot;
  logic [N-1:0]   s_ovf, w_ovf, s_alm, w_alm;
  logic           s_any, w_any;

  iot_monitor_multi #(.WIDTH(W), .CHANNELS(N), .SATURATE(1'b1),
                      .HIGH_THRESH(HI), .LOW_THRESH(LO)) dut_sat (
    .clk(clk), .rst(rst), .change(change), .on_off(on_off), .clear(clear),
    .counter_out(s_cnt), .total_out(s_tot), .overflow(s_ovf),
    .alarm(s_alm), .any_alarm(s_any));

  iot_monitor_multi #(.WIDTH(W), .CHANNELS(N), .SATURATE(1'b0),
                      .HIGH_THRESH(HI), .LOW_THRESH(LO)) dut_wrap (
    .clk(clk), .rst(rst), .change(change), .on_off(on_off), .clear(clear),
    .counter_out(w_cnt), .total_out(w_tot), .overflow(w_ovf),
    .alarm(w_alm), .any_alarm(w_any));

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model (index 0 = saturate, 1 = wrap) ----------------
  int m_cnt [2][N];
  bit m_ovf [2][N];
  bit m_alm [2][N];
  bit m_any [2];
  int m_tot [2];

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < N; i++) begin
        m_cnt[m][i] = 0; m_ovf[m][i] = 0; m_alm[m][i] = 0;
      end
      m_any[m] = 0; m_tot[m] = 0;
    end
  endtask

  // One rising edge: aggregates/alarms see the counts from before the edge.
  task automatic model_edge();
    for (int m = 0; m < 2; m++) begin
      int sum = 0;
      bit any = 0;
      for (int i = 0; i < N; i++) begin
        sum += m_cnt[m][i];
        any |= m_alm[m][i];
      end
      m_tot[m] = sum;
      m_any[m] = any;
      for (int i = 0; i < N; i++) begin
        if (!m_alm[m][i] && m_cnt[m][i] >= HI) m_alm[m][i] = 1;
        else if (m_alm[m][i] && m_cnt[m][i] <= LO) m_alm[m][i] = 0;
      end
      for (int i = 0; i < N; i++) begin
        int v = m_cnt[m][i];
        if (clear[i]) begin
          v = 0; m_ovf[m][i] = 0;
        end else if (change[i]) begin
          v = on_off[i] ? v + 1 : v - 1;
          if (v > MAXV) begin v = (m == 0) ? MAXV : 0; m_ovf[m][i] = 1; end
          if (v < 0)    begin v = (m == 0) ? 0 : MAXV; m_ovf[m][i] = 1; end
        end
        m_cnt[m][i] = v;
      end
    end
  endtask

  task automatic check_inst(input int m, input logic [N*W-1:0] cnt, input logic [TW-1:0] tot,
                            input logic [N-1:0] ovf, input logic [N-1:0] alm, input logic any);
    logic [N*W-1:0] e_cnt;
    logic [N-1:0]   e_ovf, e_alm;
    logic [31:0]    tmp;
    for (int i = 0; i < N; i++) begin
      tmp = m_cnt[m][i];
      e_cnt[i*W +: W] = tmp[W-1:0];
      e_ovf[i] = m_ovf[m][i];
      e_alm[i] = m_alm[m][i];
    end
    tmp = m_tot[m];
    chk($sformatf("m%0d_counter_out", m), 64'(cnt), 64'(e_cnt));
    chk($sformatf("m%0d_total_out", m), 64'(tot), 64'(tmp[TW-1:0]));
    chk($sformatf("m%0d_overflow", m), 64'(ovf), 64'(e_ovf));
    chk($sformatf("m%0d_alarm", m), 64'(alm), 64'(e_alm));
    chk($sformatf("m%0d_any_alarm", m), 64'(any), 64'(m_any[m]));
  endtask

  task automatic check_all();
    check_inst(0, s_cnt, s_tot, s_ovf, s_alm, s_any);
    check_inst(1, w_cnt, w_tot, w_ovf, w_alm, w_any);
  endtask

  // ---------------- driver: called at a falling edge, returns at the next one ----------------
  task automatic step(input logic [N-1:0] c, input logic [N-1:0] o, input logic [N-1:0] cl);
    change = c; on_off = o; clear = cl;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    change = '0; on_off = '0; clear = '0;
    check_all();
  endtask

  task automatic idle(); step('0, '0, '0); endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [N-1:0]   c;
    logic [N-1:0]   o;
    logic [N-1:0]   cl;
    logic [N*W-1:0] exp_cnt;
    logic [TW-1:0]  exp_tot;
  } vec_t;

  vec_t tbl [8];

  initial begin
    logic [N-1:0] rc, ro, rcl;

    tbl[0] = '{4'b0001, 4'b0001, 4'b0000, 32'd1, 10'd0};
    tbl[1] = '{4'b0001, 4'b0001, 4'b0000, 32'd2, 10'd1};
    tbl[2] = '{4'b0001, 4'b0001, 4'b0000, 32'd3, 10'd2};
    tbl[3] = '{4'b0001, 4'b0001, 4'b0000, 32'd4, 10'd3};
    tbl[4] = '{4'b0001, 4'b0001, 4'b0000, 32'd5, 10'd4};
    tbl[5] = '{4'b0001, 4'b0000, 4'b0000, 32'd4, 10'd5};
    tbl[6] = '{4'b0001, 4'b0000, 4'b0000, 32'd3, 10'd4};
    tbl[7] = '{4'b0000, 4'b0000, 4'b0000, 32'd3, 10'd3};

    model_reset();
    @(negedge clk);
    chk("reset_hold_cnt", 64'(s_cnt), 64'd0);
    rst = 1'b0;

    // Asynchronous reset between edges.
    for (int k = 0; k < 3; k++) step(4'b0001, 4'b0001, '0);
    chk("pre_reset_ch0", 64'(s_cnt[7:0]), 64'd3);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_cnt", 64'(s_cnt), 64'd0);
    chk("async_rst_tot", 64'(s_tot), 64'd0);
    chk("async_rst_ovf", 64'(s_ovf), 64'd0);
    chk("async_rst_alm", 64'(s_alm), 64'd0);
    chk("async_rst_wcnt", 64'(w_cnt), 64'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    check_all();
    step(4'b0001, 4'b0001, '0);
    chk("post_reset_ch0", 64'(s_cnt[7:0]), 64'd1);
    step('0, '0, 4'b0001);

    // Count up / down table.
    for (int i = 0; i < 8; i++) begin
      step(tbl[i].c, tbl[i].o, tbl[i].cl);
      chk($sformatf("tbl%0d_sat_cnt", i), 64'(s_cnt), 64'(tbl[i].exp_cnt));
      chk($sformatf("tbl%0d_sat_tot", i), 64'(s_tot), 64'(tbl[i].exp_tot));
      chk($sformatf("tbl%0d_wrap_cnt", i), 64'(w_cnt), 64'(tbl[i].exp_cnt));
    end

    // Underflow on ch1, then clear.
    step(4'b0010, 4'b0000, '0);
    chk("uflow_sat_ch1", 64'(s_cnt[15:8]), 64'd0);
    chk("uflow_sat_ovf", 64'(s_ovf[1]), 64'd1);
    chk("uflow_wrap_ch1", 64'(w_cnt[15:8]), 64'd255);
    chk("uflow_wrap_ovf", 64'(w_ovf[1]), 64'd1);
    step('0, '0, 4'b0010);
    chk("clear_ovf1", 64'(s_ovf[1]), 64'd0);
    chk("clear_ch1_wrap", 64'(w_cnt[15:8]), 64'd0);

    // Overflow on ch2.
    for (int k = 0; k < 255; k++) step(4'b0100, 4'b0100, '0);
    chk("ch2_at_max", 64'(s_cnt[23:16]), 64'd255);
    chk("ch2_no_ovf_yet", 64'(s_ovf[2]), 64'd0);
    step(4'b0100, 4'b0100, '0);
    chk("oflow_sat_ch2", 64'(s_cnt[23:16]), 64'd255);
    chk("oflow_sat_ovf", 64'(s_ovf[2]), 64'd1);
    chk("oflow_wrap_ch2", 64'(w_cnt[23:16]), 64'd0);
    chk("oflow_wrap_ovf", 64'(w_ovf[2]), 64'd1);
    step('0, '0, 4'b0100);

    // Hysteresis on ch3.
    for (int k = 0; k < 199; k++) step(4'b1000, 4'b1000, '0);
    idle();
    chk("hyst_199_alarm", 64'(s_alm[3]), 64'd0);
    step(4'b1000, 4'b1000, '0);
    chk("hyst_200_cnt", 64'(s_cnt[31:24]), 64'd200);
    chk("hyst_200_nolag", 64'(s_alm[3]), 64'd0);
    idle();
    chk("hyst_set_alarm", 64'(s_alm[3]), 64'd1);
    chk("hyst_any_lag", 64'(s_any), 64'd0);
    idle();
    chk("hyst_any_set", 64'(s_any), 64'd1);
    for (int k = 0; k < 149; k++) step(4'b1000, 4'b0000, '0);
    idle();
    chk("hyst_51_held", 64'(s_alm[3]), 64'd1);
    step(4'b1000, 4'b0000, '0);
    idle();
    chk("hyst_50_clear", 64'(s_alm[3]), 64'd0);
    idle();
    chk("hyst_any_clear", 64'(s_any), 64'd0);

    // Simultaneous events and clear-over-change priority.
    step('0, '0, 4'b1111);
    idle();
    step(4'b1111, 4'b1111, '0);
    chk("simul_cnt", 64'(s_cnt), 64'h01010101);
    chk("simul_tot_lag", 64'(s_tot), 64'd0);
    step(4'b0001, 4'b0001, 4'b0001);
    chk("simul_tot", 64'(s_tot), 64'd4);
    chk("clear_beats_change", 64'(s_cnt), 64'h01010100);
    idle();
    chk("clear_tot", 64'(s_tot), 64'd3);

    // Random walk: biased up, then biased down, with rare clears.
    for (int ph = 0; ph < 2; ph++) begin
      for (int k = 0; k < 600; k++) begin
        rc  = N'($urandom);
        rcl = ($urandom_range(0, 63) == 0) ? N'($urandom) : '0;
        for (int i = 0; i < N; i++)
          ro[i] = (ph == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
        step(rc, ro, rcl);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
